// File: rtl/plic_lite.sv
// plic_lite: compact platform interrupt controller. Synchronises NUM_SRC raw
// requests, gates them per source (edge/level), arbitrates by priority and
// exposes PRIO/PENDING/ENABLE/EDGE/THRESHOLD/CLAIM registers on a word port.
module plic_lite #(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned PRIO_W      = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               reg_we,
  input  logic               reg_re,
  input  logic [7:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               reg_rvalid,
  output logic               ext_irq
);

  localparam int unsigned ID_W   = 5;
  localparam int unsigned WORD_W = 6;

  localparam logic [WORD_W-1:0] W_PENDING = WORD_W'(32);
  localparam logic [WORD_W-1:0] W_ENABLE  = WORD_W'(33);
  localparam logic [WORD_W-1:0] W_EDGE    = WORD_W'(34);
  localparam logic [WORD_W-1:0] W_THRESH  = WORD_W'(35);
  localparam logic [WORD_W-1:0] W_CLAIM   = WORD_W'(36);

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC:1]   synced;
  logic [NUM_SRC:1]   prev_q;

  logic [NUM_SRC:1]   pending_q, pending_d;
  logic [NUM_SRC:1]   insvc_q, insvc_d;
  logic [NUM_SRC:1]   enable_q, enable_d;
  logic [NUM_SRC:1]   mode_edge_q, mode_edge_d;
  logic [PRIO_W-1:0]  prio_q [1:NUM_SRC];
  logic [PRIO_W-1:0]  prio_d [1:NUM_SRC];
  logic [PRIO_W-1:0]  thresh_q, thresh_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               ext_irq_q, ext_irq_d;

  logic [NUM_SRC:1]   eligible;
  logic [NUM_SRC:1]   gw_set;
  logic [NUM_SRC:1]   claim_clr;
  logic [ID_W-1:0]    win_id;
  logic [PRIO_W-1:0]  win_prio;
  logic [WORD_W-1:0]  word;
  logic               rd_acc;

  assign synced     = sync_q[SYNC_STAGES-1];
  assign reg_rdata  = rdata_q;
  assign reg_rvalid = rvalid_q;
  assign ext_irq    = ext_irq_q;

  // Synchroniser chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= src_irq;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= synced;
    end
  end

  // Sources that may currently raise the interrupt line.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      eligible[i] = pending_q[i] & enable_q[i] & (prio_q[i] > thresh_q);
    end
  end

  // Highest priority wins; strict compare keeps the lowest ID on ties.
  always_comb begin
    win_id   = '0;
    win_prio = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      if (eligible[i] && (prio_q[i] > win_prio)) begin
        win_id   = ID_W'(i);
        win_prio = prio_q[i];
      end
    end
  end

  // Next-state: gateways, register writes, reads and claim side effects.
  always_comb begin
    word        = reg_addr[7:2];
    rd_acc      = reg_re & ~reg_we;
    prio_d      = prio_q;
    enable_d    = enable_q;
    mode_edge_d = mode_edge_q;
    thresh_d    = thresh_q;
    insvc_d     = insvc_q;
    rdata_d     = rdata_q;
    rvalid_d    = rd_acc;
    claim_clr   = '0;
    gw_set      = '0;

    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      if (mode_edge_q[i]) gw_set[i] = synced[i] & ~prev_q[i];
      else                gw_set[i] = synced[i] & ~insvc_q[i] & ~pending_q[i];
    end

    if (reg_we) begin
      for (int unsigned i = 1; i <= NUM_SRC; i++) begin
        if (word == WORD_W'(i)) prio_d[i] = reg_wdata[PRIO_W-1:0];
      end
      case (word)
        W_ENABLE: enable_d    = reg_wdata[NUM_SRC:1];
        W_EDGE:   mode_edge_d = reg_wdata[NUM_SRC:1];
        W_THRESH: thresh_d    = reg_wdata[PRIO_W-1:0];
        W_CLAIM: begin
          for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            if (reg_wdata[ID_W-1:0] == ID_W'(i)) insvc_d[i] = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (rd_acc) begin
      rdata_d = '0;
      for (int unsigned i = 1; i <= NUM_SRC; i++) begin
        if (word == WORD_W'(i)) rdata_d = 32'(prio_q[i]);
      end
      case (word)
        W_PENDING: rdata_d = 32'({pending_q, 1'b0});
        W_ENABLE:  rdata_d = 32'({enable_q, 1'b0});
        W_EDGE:    rdata_d = 32'({mode_edge_q, 1'b0});
        W_THRESH:  rdata_d = 32'(thresh_q);
        W_CLAIM: begin
          rdata_d = 32'(win_id);
          for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            if (win_id == ID_W'(i)) begin
              claim_clr[i] = 1'b1;
              insvc_d[i]   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    // A new edge arriving with its own claim keeps the source pending.
    pending_d = (pending_q & ~claim_clr) | gw_set;
    ext_irq_d = |eligible;
  end

  // Architectural state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i <= NUM_SRC; i++) prio_q[i] <= '0;
      pending_q   <= '0;
      insvc_q     <= '0;
      enable_q    <= '0;
      mode_edge_q <= '0;
      thresh_q    <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      ext_irq_q   <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      pending_q   <= pending_d;
      insvc_q     <= insvc_d;
      enable_q    <= enable_d;
      mode_edge_q <= mode_edge_d;
      thresh_q    <= thresh_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      ext_irq_q   <= ext_irq_d;
    end
  end

endmodule

// File: tb/tb_plic_lite.sv
// Scoreboard bench for plic_lite: stimulus queues expectations, a negedge
// monitor pops them when read data or sampled outputs become due.
module tb_plic_lite;

  localparam int unsigned NUM_SRC = 8;

  localparam logic [7:0] A_PENDING = 8'h80;
  localparam logic [7:0] A_ENABLE  = 8'h84;
  localparam logic [7:0] A_EDGE    = 8'h88;
  localparam logic [7:0] A_THRESH  = 8'h8C;
  localparam logic [7:0] A_CLAIM   = 8'h90;

  localparam int SEL_IRQ    = 0;
  localparam int SEL_RVALID = 1;
  localparam int SEL_RDATA  = 2;
  localparam int SEL_QEMPTY = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_SRC-1:0] src_irq;
  logic               reg_we;
  logic               reg_re;
  logic [7:0]         reg_addr;
  logic [31:0]        reg_wdata;
  logic [31:0]        reg_rdata;
  logic               reg_rvalid;
  logic               ext_irq;

  int errors = 0;
  int checks = 0;

  // Expected read responses, in issue order.
  string       rd_name_q[$];
  logic [31:0] rd_data_q[$];
  // Expected output values to sample at the next falling edge.
  int          smp_sel_q[$];
  string       smp_name_q[$];
  logic [31:0] smp_data_q[$];

  plic_lite #(.NUM_SRC(NUM_SRC), .PRIO_W(3), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_irq    (src_irq),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .reg_rvalid (reg_rvalid),
    .ext_irq    (ext_irq)
  );

  always #5 clk = ~clk;

  // Monitor: sole owner of the check counters.
  string       m_name;
  logic [31:0] m_exp;
  logic [31:0] m_act;
  int          m_sel;
  always @(negedge clk) begin
    while (smp_sel_q.size() > 0) begin
      m_sel  = smp_sel_q.pop_front();
      m_name = smp_name_q.pop_front();
      m_exp  = smp_data_q.pop_front();
      case (m_sel)
        SEL_IRQ:    m_act = 32'(ext_irq);
        SEL_RVALID: m_act = 32'(reg_rvalid);
        SEL_RDATA:  m_act = reg_rdata;
        default:    m_act = 32'(rd_data_q.size());
      endcase
      checks++;
      if (m_act !== m_exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h, required 0x%08h", m_name, m_act, m_exp);
      end
    end
    if (rst_n && reg_rvalid) begin
      checks++;
      if (rd_data_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid: got rdata 0x%08h, required no rvalid", reg_rdata);
      end else begin
        m_name = rd_name_q.pop_front();
        m_exp  = rd_data_q.pop_front();
        if (reg_rdata !== m_exp) begin
          errors++;
          $display("FAIL %s: got 0x%08h, required 0x%08h", m_name, reg_rdata, m_exp);
        end
      end
    end
  end

  task automatic expect_now(input int sel, input string nm, input logic [31:0] v);
    smp_sel_q.push_back(sel);
    smp_name_q.push_back(nm);
    smp_data_q.push_back(v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    @(posedge clk); #1;
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input string nm, input logic [31:0] e);
    rd_name_q.push_back(nm);
    rd_data_q.push_back(e);
    reg_re = 1'b1; reg_addr = a;
    @(posedge clk); #1;
    reg_re = 1'b0;
  endtask

  task automatic wr_rd(input logic [7:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_re = 1'b1; reg_addr = a; reg_wdata = d;
    @(posedge clk); #1;
    reg_we = 1'b0; reg_re = 1'b0;
  endtask

  // One-cycle pulse on the given raw source bits, then wait until
  // pending and ext_irq have had time to respond.
  task automatic pulse(input logic [NUM_SRC-1:0] bits);
    src_irq = bits;
    idle(1);
    src_irq = '0;
    idle(4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; src_irq = '0; reg_we = 1'b0; reg_re = 1'b0;
    reg_addr = '0; reg_wdata = '0;
    idle(3);
    expect_now(SEL_IRQ,    "reset_ext_irq", 32'd0);
    expect_now(SEL_RVALID, "reset_rvalid",  32'd0);
    expect_now(SEL_RDATA,  "reset_rdata",   32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    rd(A_PENDING, "reset_pending", 32'h0);
    rd(A_CLAIM,   "reset_claim",   32'h0);

    // Edge source 3, PRIO 2: ext_irq rises 4 cycles after the input edge.
    wr(8'h0C, 32'd2);
    wr(A_EDGE, 32'h3C);
    wr(A_ENABLE, 32'h3C);
    src_irq = 8'h04;
    idle(1);
    src_irq = '0;
    idle(2);
    expect_now(SEL_IRQ, "s1_irq_at_3", 32'd0);
    idle(1);
    expect_now(SEL_IRQ, "s1_irq_at_4", 32'd1);
    rd(A_PENDING, "s1_pending", 32'h08);
    rd(A_CLAIM,   "s1_claim",   32'd3);
    idle(1);
    expect_now(SEL_IRQ, "s1_irq_after_claim", 32'd0);
    wr(A_CLAIM, 32'd3);

    // Priority ordering: 4 (PRIO 6) first, then tie 2/5 by ID.
    wr(8'h08, 32'd4);
    wr(8'h14, 32'd4);
    wr(8'h10, 32'd6);
    pulse(8'h1A);
    expect_now(SEL_IRQ, "s2_irq", 32'd1);
    rd(A_PENDING, "s2_pending", 32'h34);
    rd(A_CLAIM, "s2_claim1", 32'd4);
    rd(A_CLAIM, "s2_claim2", 32'd2);
    rd(A_CLAIM, "s2_claim3", 32'd5);
    rd(A_CLAIM, "s2_claim4", 32'd0);
    expect_now(SEL_IRQ, "s2_irq_after_claims", 32'd0);
    wr(A_CLAIM, 32'd4);
    wr(A_CLAIM, 32'd2);
    wr(A_CLAIM, 32'd5);

    // Level source 1 held high: no re-pend while in service.
    wr(8'h04, 32'd3);
    wr(A_ENABLE, 32'h3E);
    src_irq = 8'h01;
    idle(4);
    expect_now(SEL_IRQ, "s3_irq", 32'd1);
    rd(A_PENDING, "s3_pending", 32'h02);
    rd(A_CLAIM, "s3_claim", 32'd1);
    idle(4);
    rd(A_PENDING, "s3_no_repend", 32'h0);
    expect_now(SEL_IRQ, "s3_irq_in_service", 32'd0);
    wr(A_CLAIM, 32'd9);
    idle(2);
    rd(A_PENDING, "s3_complete9_ignored", 32'h0);
    wr(A_CLAIM, 32'd1);
    idle(1);
    rd(A_PENDING, "s3_repend", 32'h02);
    expect_now(SEL_IRQ, "s3_irq_reassert", 32'd1);
    src_irq = '0;
    idle(4);
    rd(A_CLAIM, "s3_claim_after_drop", 32'd1);
    wr(A_CLAIM, 32'd1);
    idle(3);
    rd(A_PENDING, "s3_pending_clear", 32'h0);
    expect_now(SEL_IRQ, "s3_irq_clear", 32'd0);

    // Threshold masking.
    wr(8'h08, 32'd5);
    wr(A_THRESH, 32'd5);
    pulse(8'h02);
    expect_now(SEL_IRQ, "s4_irq_masked", 32'd0);
    rd(A_PENDING, "s4_pending", 32'h04);
    rd(A_CLAIM, "s4_claim_masked", 32'd0);
    wr(A_THRESH, 32'd4);
    expect_now(SEL_IRQ, "s4_irq_same_cycle", 32'd0);
    idle(1);
    expect_now(SEL_IRQ, "s4_irq_next_cycle", 32'd1);
    rd(A_THRESH, "s4_thresh", 32'd4);
    rd(A_CLAIM, "s4_claim", 32'd2);
    wr(A_CLAIM, 32'd2);
    wr(A_THRESH, 32'd0);

    // Disable keeps pending; re-enable restores the request.
    pulse(8'h04);
    expect_now(SEL_IRQ, "dis_irq_before", 32'd1);
    wr(A_ENABLE, 32'h36);
    idle(1);
    expect_now(SEL_IRQ, "dis_irq_off", 32'd0);
    rd(A_PENDING, "dis_pending_kept", 32'h08);
    wr(A_ENABLE, 32'h3E);
    idle(1);
    expect_now(SEL_IRQ, "dis_irq_on", 32'd1);
    rd(A_CLAIM, "dis_claim", 32'd3);
    wr(A_CLAIM, 32'd3);

    // Edge source 6 re-pulsed while in service, plus register map edges.
    wr(8'h18, 32'd1);
    wr(A_EDGE, 32'h7C);
    wr(A_ENABLE, 32'h7E);
    pulse(8'h20);
    rd(A_CLAIM, "s5_claim", 32'd6);
    pulse(8'h20);
    rd(A_PENDING, "s5_repend", 32'h40);
    expect_now(SEL_IRQ, "s5_irq", 32'd1);
    wr(8'h18, 32'hFF);
    rd(8'h18, "s5_prio_mask", 32'h7);
    rd(8'h00, "unmapped_00", 32'h0);
    rd(8'hFC, "unmapped_fc", 32'h0);
    rd(8'h24, "unmapped_prio9", 32'h0);
    wr(A_ENABLE, 32'h1FF);
    rd(A_ENABLE, "enable_bit0", 32'h1FE);
    wr(A_ENABLE, 32'h7E);
    rd(A_EDGE, "edge_readback", 32'h7C);
    wr(A_PENDING, 32'h0);
    rd(A_PENDING, "pending_ro", 32'h40);
    wr_rd(A_THRESH, 32'd3);
    rd(A_THRESH, "we_re_write_done", 32'd3);
    wr(A_THRESH, 32'd0);

    // Reset during pending + in-service with a read in flight.
    reg_re = 1'b1; reg_addr = A_CLAIM;
    @(posedge clk); #1;
    rst_n = 1'b0; reg_re = 1'b0;
    expect_now(SEL_IRQ,    "rst_mid_irq",    32'd0);
    expect_now(SEL_RVALID, "rst_mid_rvalid", 32'd0);
    expect_now(SEL_RDATA,  "rst_mid_rdata",  32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    rd(A_CLAIM,   "rst_claim",   32'd0);
    rd(A_PENDING, "rst_pending", 32'h0);
    expect_now(SEL_IRQ, "rst_irq_after", 32'd0);

    idle(3);
    expect_now(SEL_QEMPTY, "read_queue_drained", 32'd0);
    idle(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
